// File: rtl/word_serializer_if.sv
// Handshake bundle for word_serializer.
// Upstream side: in_valid/in_data/in_ready plus flush.
// Downstream side: ser_out/ser_valid/ser_last/ser_ready.
// Status: busy.
// master = the environment that drives words in and consumes bits.
// slave  = the serializer itself.
interface word_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             flush;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_ready;
    logic             ser_last;
    logic             busy;

    modport master (
        output in_valid, in_data, flush, ser_ready,
        input  in_ready, ser_out, ser_valid, ser_last, busy
    );

    modport slave (
        input  in_valid, in_data, flush, ser_ready,
        output in_ready, ser_out, ser_valid, ser_last, busy
    );
endinterface

// File: rtl/word_serializer.sv
// word_serializer: loads a WIDTH-bit word and emits it one bit per
// ser_valid/ser_ready transfer, MSB or LSB first.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - word_serializer_if.slave (word input, serial output, flush, busy)
// All outputs come straight from flops.
module word_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    word_serializer_if.slave  bus
);

    localparam int unsigned     CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q,     state_d;
    logic [WIDTH-1:0] shreg_q,     shreg_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             ser_out_q,   ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             ser_last_q,  ser_last_d;
    logic             in_ready_q,  in_ready_d;
    logic             busy_q,      busy_d;

    // Bit presented first from a register aligned for the chosen order.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Rotate so the next bit to send lands in the head position.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], w[WIDTH-1]} : {w[0], w[WIDTH-1:1]};
    endfunction

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        ser_out_d   = ser_out_q;
        ser_valid_d = ser_valid_q;
        ser_last_d  = ser_last_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;

        unique case (state_q)
            IDLE: begin
                ser_valid_d = 1'b0;
                ser_last_d  = 1'b0;
                // flush outranks in_valid
                if (bus.in_valid && !bus.flush) begin
                    state_d     = SHIFT;
                    shreg_d     = bus.in_data;
                    cnt_d       = '0;
                    ser_out_d   = head_bit(bus.in_data);
                    ser_valid_d = 1'b1;
                    ser_last_d  = 1'b0;
                    in_ready_d  = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            SHIFT: begin
                // a transfer coinciding with flush is simply the end of the word
                if (bus.flush || (bus.ser_ready && cnt_q == LAST_IDX)) begin
                    state_d     = IDLE;
                    ser_valid_d = 1'b0;
                    ser_last_d  = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end else if (bus.ser_ready) begin
                    shreg_d    = advance(shreg_q);
                    cnt_d      = cnt_q + CNT_W'(1);
                    ser_out_d  = head_bit(shreg_d);
                    ser_last_d = (cnt_d == LAST_IDX);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            ser_last_q  <= ser_last_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.ser_out   = ser_out_q;
    assign bus.ser_valid = ser_valid_q;
    assign bus.ser_last  = ser_last_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;

endmodule

// File: doc/word_serializer.md
WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 Parameter WIDTH, default 8: bits per parallel word; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserted while 0.
REQ-005 in_valid  input  1  upstream word present on in_data.
REQ-006 in_data  input  WIDTH  parallel word to serialize.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 flush  input  1  synchronous abort of the word in progress.
REQ-009 ser_out  output  1  current serial bit.
REQ-010 ser_valid  output  1  ser_out holds a valid bit.
REQ-011 ser_ready  input  1  downstream consumes the bit this cycle.
REQ-012 ser_last  output  1  the current bit is the final bit of its word.
REQ-013 busy  output  1  a word is held (state SHIFT).

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and SHIFT.
REQ-015 in_ready SHALL be 1 in IDLE and 0 in SHIFT; busy SHALL be the inverse of in_ready.
REQ-016 Accept: in IDLE with in_valid=1 and flush=0, the block SHALL load in_data into the shift register, clear the bit counter and enter SHIFT on the same edge.
REQ-017 Latency: the first bit SHALL appear on ser_out with ser_valid=1 in the cycle after acceptance.
REQ-018 ser_out, ser_valid and ser_last SHALL be driven directly from flops.
REQ-019 Transfer: a bit transfers on an edge where ser_valid=1 and ser_ready=1; the next bit SHALL be presented in the following cycle.
REQ-020 Back-pressure: while ser_valid=1 and ser_ready=0, ser_out, ser_last and the bit counter SHALL hold unchanged.
REQ-021 Bit order: MSB_FIRST=1 SHALL send in_data[WIDTH-1] down to in_data[0]; MSB_FIRST=0 SHALL send in_data[0] up to in_data[WIDTH-1].
REQ-022 The bit counter SHALL be $clog2(WIDTH) bits wide, counting 0..WIDTH-1 with no wrap past WIDTH-1.
REQ-023 ser_last SHALL be 1 exactly while bit number WIDTH-1 of the word is presented.
REQ-024 End of word: on transfer of the last bit, the FSM SHALL return to IDLE and ser_valid, ser_last SHALL be 0 in the next cycle.
REQ-025 Spacing: back-to-back words SHALL be separated by exactly one IDLE cycle with in_ready=1; no accept is possible in SHIFT.
REQ-026 In IDLE, ser_valid SHALL be 0 and ser_out SHALL hold its last value.
REQ-027 Flush in SHIFT SHALL discard the remaining bits, force ser_valid=0 and ser_last=0 and return to IDLE on that edge; a bit whose transfer coincides with flush counts as transferred.
REQ-028 Flush in IDLE together with in_valid=1 SHALL block acceptance; flush has priority.
REQ-029 in_data changes while in SHIFT SHALL have no effect on the word being sent.

Reset
REQ-030 While reset=0, the block SHALL enter IDLE immediately, independent of clk.
REQ-031 Reset values: shift register 0, bit counter 0, ser_out 0, ser_valid 0, ser_last 0, in_ready 1, busy 0.
REQ-032 Reset asserted mid-word SHALL drop the word; after release, no residual bits SHALL be emitted.
REQ-033 The first accept SHALL be possible on the first rising edge after reset rises to 1.

Verification
REQ-034 WIDTH=8, MSB_FIRST=1, ser_ready=1, in_data=8'hA5 -> ser_out 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting 1 cycle after accept; ser_last only on the 8th; in_ready=1 on the following cycle.
REQ-035 MSB_FIRST=0, in_data=8'h01 -> first bit 1, then seven 0s; ser_last on the 8th bit.
REQ-036 8'hC3 sent, ser_ready=0 for 3 cycles at bit 2 -> ser_out and ser_last held for 3 cycles; sequence intact; total 11 valid cycles.
REQ-037 flush during bit 4 of 8'hFF -> ser_valid=0 next cycle, in_ready=1; next word 8'h00 is sent complete and clean.
REQ-038 reset=0 during bit 5 -> all outputs take REQ-031 values immediately with no clk edge; no bits after release until a new accept.
REQ-039 in_valid held high with words 8'h12, 8'h34 -> accepts spaced exactly 9 cycles apart; in IDLE, flush=1 with in_valid=1 -> no accept.
